// File: rtl/seven_segment_readback.sv
// rtl/seven_segment_readback.sv - two-digit seven-segment readback decoder with stability filter
//
// Purpose:
//   Samples a time-multiplexed seven-segment digit bus (units first, then tens).
//   Each pattern is decoded back to a digit or blank.
//   Illegal and half-blank frames are rejected.
//   A value is published only after it has been seen for STABLE_FRAMES consecutive legal frames.
//
// Parameters:
//   STABLE_FRAMES  consecutive identical legal frames before publishing (1..15)
//   FRAME_TIMEOUT  max cycles spent waiting for the tens digit (>=1)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   seg_in       active-low segments, bit6=a .. bit0=g
//   digit_sel    0 = units digit, 1 = tens digit
//   seg_valid    seg_in/digit_sel qualifier
//   value_out    last published value, 7'h7F = blank display
//   value_valid  one-cycle pulse when value_out updates
//   seg_err      one-cycle pulse on an illegal or ambiguous frame
//   frame_tmo    one-cycle pulse when a partial frame is abandoned
//   err_count    (SEG_ERR_COUNT_EN only) saturating count of seg_err + frame_tmo pulses
//
// Optional feature macro: SEG_ERR_COUNT_EN
module seven_segment_readback #(
  parameter int STABLE_FRAMES = 2,
  parameter int FRAME_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       digit_sel,
  input  logic       seg_valid,
  output logic [6:0] value_out,
  output logic       value_valid,
  output logic       seg_err,
  output logic       frame_tmo
`ifdef SEG_ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [1:0] WAIT_UNITS = 2'd0;
  localparam logic [1:0] WAIT_TENS  = 2'd1;
  localparam logic [1:0] DECODE     = 2'd2;

  localparam int TW = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(FRAME_TIMEOUT - 1);
  localparam logic [3:0] SF = 4'(STABLE_FRAMES);

  logic [1:0]    state;
  logic [6:0]    units_q;
  logic [6:0]    tens_q;
  logic [TW-1:0] tmo_cnt;
  logic [6:0]    candidate;
  logic [3:0]    match_cnt;

  // Returns {legal, digit}; digit 4'hF marks the blank pattern.
  function automatic logic [4:0] decode_digit(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b0000001: r = 5'b1_0000;
      7'b1001111: r = 5'b1_0001;
      7'b0010010: r = 5'b1_0010;
      7'b0000110: r = 5'b1_0011;
      7'b1001100: r = 5'b1_0100;
      7'b0100100: r = 5'b1_0101;
      7'b0100000: r = 5'b1_0110;
      7'b0001111: r = 5'b1_0111;
      7'b0000000: r = 5'b1_1000;
      7'b0000100: r = 5'b1_1001;
      7'b1111111: r = 5'b1_1111;
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  logic [4:0] du;
  logic [4:0] dt;
  logic       u_blank;
  logic       t_blank;
  logic       frame_err;
  logic [6:0] frame_val;
  logic [6:0] cand_next;
  logic [3:0] cnt_next;
  logic       publish;
  logic       tmo_fire;

  always_comb begin
    du        = decode_digit(units_q);
    dt        = decode_digit(tens_q);
    u_blank   = (du[3:0] == 4'hF);
    t_blank   = (dt[3:0] == 4'hF);
    // A half-blank frame is ambiguous (e.g. a scan glitch), so it is treated like an illegal one.
    frame_err = !du[4] || !dt[4] || (u_blank != t_blank);
    frame_val = u_blank ? 7'h7F : ({3'b000, dt[3:0]} * 7'd10 + {3'b000, du[3:0]});

    cand_next = candidate;
    cnt_next  = match_cnt;
    if (frame_val == candidate) begin
      if (match_cnt < SF) cnt_next = match_cnt + 4'd1;
    end else begin
      cand_next = frame_val;
      cnt_next  = 4'd1;
    end
    publish  = !frame_err && (cnt_next == SF) && (cand_next != value_out);

    // A tens sample or a units restart on the last cycle takes priority over the timeout.
    tmo_fire = (state == WAIT_TENS) && !seg_valid && (tmo_cnt == TMO_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_UNITS;
      units_q     <= 7'h7F;
      tens_q      <= 7'h7F;
      tmo_cnt     <= '0;
      candidate   <= 7'h7F;
      match_cnt   <= 4'd0;
      value_out   <= 7'h7F;
      value_valid <= 1'b0;
      seg_err     <= 1'b0;
      frame_tmo   <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      seg_err     <= 1'b0;
      frame_tmo   <= 1'b0;
      case (state)
        WAIT_UNITS: begin
          if (seg_valid && !digit_sel) begin
            units_q <= seg_in;
            tmo_cnt <= '0;
            state   <= WAIT_TENS;
          end
        end
        WAIT_TENS: begin
          if (seg_valid && digit_sel) begin
            tens_q <= seg_in;
            state  <= DECODE;
          end else if (seg_valid) begin
            units_q <= seg_in;
            tmo_cnt <= '0;
          end else if (tmo_fire) begin
            frame_tmo <= 1'b1;
            state     <= WAIT_UNITS;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        DECODE: begin
          state <= WAIT_UNITS;
          if (frame_err) begin
            seg_err   <= 1'b1;
            match_cnt <= 4'd0;
          end else begin
            candidate <= cand_next;
            match_cnt <= cnt_next;
            if (publish) begin
              value_out   <= cand_next;
              value_valid <= 1'b1;
            end
          end
        end
        default: state <= WAIT_UNITS;
      endcase
    end
  end

`ifdef SEG_ERR_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if ((((state == DECODE) && frame_err) || tmo_fire) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seven_segment_readback.sv
// tb/tb_seven_segment_readback.sv - scoreboard bench for seven_segment_readback
module tb_seven_segment_readback;

  localparam int STABLE_FRAMES = 2;
  localparam int FRAME_TIMEOUT = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = 7'h7F;
  logic       digit_sel = 1'b0;
  logic       seg_valid = 1'b0;
  logic [6:0] value_out;
  logic       value_valid;
  logic       seg_err;
  logic       frame_tmo;
`ifdef SEG_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  seven_segment_readback #(
    .STABLE_FRAMES(STABLE_FRAMES),
    .FRAME_TIMEOUT(FRAME_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seg_in(seg_in),
    .digit_sel(digit_sel),
    .seg_valid(seg_valid),
    .value_out(value_out),
    .value_valid(value_valid),
    .seg_err(seg_err),
    .frame_tmo(frame_tmo)
`ifdef SEG_ERR_COUNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Segment pattern for each digit 0..9; index 10 is the blank pattern.
  logic [6:0] pats [0:10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
                              7'b1111111};

  typedef struct {
    int kind;   // 0 = value_valid, 1 = seg_err, 2 = frame_tmo
    int value;  // value_out expected while the pulse is high
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int m_value = 127;
  int m_cand  = 127;
  int m_cnt   = 0;
  int m_errs  = 0;

  function automatic int pat_digit(input logic [6:0] p);
    for (int i = 0; i <= 10; i++) if (pats[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [6:0] rand_illegal();
    logic [6:0] p;
    do p = 7'($urandom); while (pat_digit(p) >= 0);
    return p;
  endfunction

  task automatic push_exp(input int kind, input int value);
    exp_t e;
    e.kind  = kind;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_value = 127;
    m_cand  = 127;
    m_cnt   = 0;
    m_errs  = 0;
    exp_q.delete();
  endtask

  task automatic model_frame(input logic [6:0] u, input logic [6:0] t);
    int du, dt, v;
    du = pat_digit(u);
    dt = pat_digit(t);
    if (du < 0 || dt < 0 || ((du == 10) != (dt == 10))) begin
      m_cnt = 0;
      m_errs++;
      push_exp(1, m_value);
    end else begin
      v = (du == 10) ? 127 : dt * 10 + du;
      if (v == m_cand) m_cnt = (m_cnt + 1 > STABLE_FRAMES) ? STABLE_FRAMES : m_cnt + 1;
      else begin
        m_cand = v;
        m_cnt  = 1;
      end
      if (m_cnt == STABLE_FRAMES && m_cand != m_value) begin
        m_value = m_cand;
        push_exp(0, m_value);
      end
    end
  endtask

  task automatic drive(input logic v, input logic sel, input logic [6:0] p);
    seg_valid = v;
    digit_sel = sel;
    seg_in    = p;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 7'h7F);
  endtask

  // One frame; optionally a junk sample is offered during the decode cycle, which must be ignored.
  task automatic send_frame(input logic [6:0] u, input logic [6:0] t, input bit junk);
    drive(1'b1, 1'b0, u);
    model_frame(u, t);
    drive(1'b1, 1'b1, t);
    if (junk) drive(1'b1, 1'b0, 7'($urandom));
    else drive(1'b0, 1'b0, 7'h7F);
  endtask

  // Units sample followed by silence; then a stray tens sample that must be discarded.
  task automatic send_timeout(input logic [6:0] u);
    drive(1'b1, 1'b0, u);
    m_errs++;
    push_exp(2, m_value);
    idle(FRAME_TIMEOUT);
    drive(1'b1, 1'b1, pats[$urandom_range(0, 9)]);
    idle(1);
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Monitor: pops an expectation for every pulse and tracks the published value.
  int mon_value = 127;
  bit prev_pulse = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_value  = 127;
        prev_pulse = 1'b0;
      end else begin
        logic [2:0] pulses;
        exp_t e;
        int kind;
        pulses = {value_valid, seg_err, frame_tmo};
        if (pulses != 3'b000) begin
          check("pulse_shape", int'(($countones(pulses) == 1) && !prev_pulse), 1);
          kind = value_valid ? 0 : (seg_err ? 1 : 2);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse_kind", kind, -1);
          end else begin
            e = exp_q.pop_front();
            check("pulse_kind", kind, e.kind);
            if (kind == 0) mon_value = e.value;
          end
        end
        check("value_out", int'(value_out), mon_value);
        prev_pulse = (pulses != 3'b000);
      end
    end
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pu, pt;
    int ntmo;
    int r;

    // Reset state
    idle(2);
    check("reset_value_out", int'(value_out), 127);
    check("reset_pulses", int'({value_valid, seg_err, frame_tmo}), 0);
    rst = 1'b0;
    idle(2);

    // "25" three times: publishes once, after the second frame
    for (int i = 0; i < 3; i++) send_frame(pats[5], pats[2], 1'b0);
    idle(2);
    // Blank twice, then half-blank error
    for (int i = 0; i < 2; i++) send_frame(pats[10], pats[10], 1'b0);
    send_frame(pats[3], pats[10], 1'b0);
    // Illegal units, then "14" twice publishes after the error cleared match_cnt
    send_frame(7'b1110000, pats[1], 1'b0);
    for (int i = 0; i < 2; i++) send_frame(pats[4], pats[1], 1'b0);
    idle(2);
    // Timeout with a discarded tens sample afterwards
    send_timeout(pats[7]);
    idle(2);

`ifdef SEG_ERR_COUNT_EN
    check("err_count_directed", int'(err_count), m_errs);
`endif

    // Reset in the middle of WAIT_TENS
    drive(1'b1, 1'b0, pats[7]);
    seg_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check("midframe_reset_value_out", int'(value_out), 127);
    check("midframe_reset_pulses", int'({value_valid, seg_err, frame_tmo}), 0);
`ifdef SEG_ERR_COUNT_EN
    check("midframe_reset_err_count", int'(err_count), 0);
`endif
    rst = 1'b0;
    drive(1'b1, 1'b1, pats[1]);
    idle(3);

    // Randomized frames
    ntmo = 0;
    pu = pats[0];
    pt = pats[0];
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 7) == 0) drive(1'b1, 1'b1, 7'($urandom));
      if ($urandom_range(0, 7) == 0) drive(1'b1, 1'b0, 7'($urandom));
      if (r < 5) begin
        if ($urandom_range(0, 1) == 1) send_frame(rand_illegal(), pats[$urandom_range(0, 10)], $urandom_range(0, 3) == 0);
        else send_frame(pats[$urandom_range(0, 10)], rand_illegal(), $urandom_range(0, 3) == 0);
      end else if (r < 10) begin
        if ($urandom_range(0, 1) == 1) send_frame(pats[10], pats[$urandom_range(0, 9)], 1'b0);
        else send_frame(pats[$urandom_range(0, 9)], pats[10], 1'b0);
      end else if (r < 15) begin
        pu = pats[10];
        pt = pats[10];
        send_frame(pu, pt, $urandom_range(0, 3) == 0);
      end else if (r < 17 && ntmo < 2) begin
        ntmo++;
        send_timeout(pats[$urandom_range(0, 10)]);
      end else begin
        if ($urandom_range(0, 1) == 0) begin
          pu = pats[$urandom_range(0, 9)];
          pt = pats[$urandom_range(0, 3)];
        end
        send_frame(pu, pt, $urandom_range(0, 3) == 0);
      end
      idle($urandom_range(0, 2));
    end
    idle(4);

`ifdef SEG_ERR_COUNT_EN
    check("err_count_random", int'(err_count), (m_errs > 255) ? 255 : m_errs);
    for (int i = 0; i < 300; i++) send_frame(rand_illegal(), pats[1], 1'b0);
    idle(3);
    check("err_count_saturated", int'(err_count), 255);
`endif

    idle(4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
